// File: rtl/risc_pkg.sv
// Shared encodings for the RISC controller: opcodes, instruction-cycle phases
// and the ALU-operation opcode decode.
package risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath signal bundle. With RISC_CTRL_SINGLE_STEP_EN defined
// the bundle also carries the single-step request `step`.
interface risc_controller_if;

  logic [2:0] opcode;
  logic       zero;
`ifdef RISC_CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       ld_ac;
  logic       inc_pc;
  logic       ld_pc;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

`ifdef RISC_CTRL_SINGLE_STEP_EN
  modport master (
    input  opcode, zero, step,
    output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );
  modport slave (
    output opcode, zero, step,
    input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );
`else
  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );
  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );
`endif

endinterface

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer with sticky HLT state and Moore strobe decode.
// Optional single-step hold in INST_ADDR: define RISC_CTRL_SINGLE_STEP_EN.
module risc_controller
  import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    risc_controller_if.master  bus
);

    phase_t     phase_q, phase_d;
    logic       halted_q, halted_d;
    logic [2:0] phase_inc;
    logic       aluop;

    assign phase_inc = phase_q + 3'd1;
    assign aluop     = is_aluop(bus.opcode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && bus.opcode == HLT) begin
                // Halt freezes the counter in OP_FETCH until reset.
                halted_d = 1'b1;
                phase_d  = OP_FETCH;
`ifdef RISC_CTRL_SINGLE_STEP_EN
            end else if (phase_q == INST_ADDR && !bus.step) begin
                phase_d  = INST_ADDR;
`endif
            end else begin
                phase_d  = phase_t'(phase_inc);
            end
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = 1'b0;
        if (halted_q) begin
            bus.halt = 1'b1;
        end else begin
            unique case (phase_q)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = (bus.opcode == HLT);
                end
                OP_FETCH: begin
                    bus.rd = aluop;
                end
                ALU_OP: begin
                    bus.rd     = aluop;
                    bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
                    bus.ld_pc  = (bus.opcode == JMP);
                    bus.data_e = (bus.opcode == STO);
                end
                STORE: begin
                    bus.rd     = aluop;
                    bus.ld_ac  = aluop;
                    bus.ld_pc  = (bus.opcode == JMP);
                    bus.wr     = (bus.opcode == STO);
                    bus.data_e = (bus.opcode == STO);
                end
                default: ;
            endcase
        end
    end

    assign bus.phase = phase_q;

endmodule
